// File: rtl/ahb_slave_if_if.sv
// -----------------------------------------------------------------------------
// ahb_slave_if_if
// Bus bundle between the AHB master side and the AHB slave interface of the
// AHB-APB bridge. Clock and reset are not part of the bundle.
//
// Signals
//   master -> slave : hwrite, hreadyin, htrans[1:0], haddr, hwdata
//   apb side -> slave: prdata, hready_apb
//   slave outputs   : valid, tempselx[2:0], haddr1/haddr2, hwdata1/hwdata2,
//                     hwrite_reg/hwrite_reg1, hrdata, hreadyout, hresp[1:0]
// Modports
//   slave  : view used by ahb_slave_if
//   master : view used by whatever drives the bus (bench or upstream logic)
// -----------------------------------------------------------------------------
interface ahb_slave_if_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              hwrite;
    logic              hreadyin;
    logic [1:0]        htrans;
    logic [ADDR_W-1:0] haddr;
    logic [DATA_W-1:0] hwdata;
    logic [DATA_W-1:0] prdata;
    logic              hready_apb;

    logic              valid;
    logic [2:0]        tempselx;
    logic [ADDR_W-1:0] haddr1;
    logic [ADDR_W-1:0] haddr2;
    logic [DATA_W-1:0] hwdata1;
    logic [DATA_W-1:0] hwdata2;
    logic              hwrite_reg;
    logic              hwrite_reg1;
    logic [DATA_W-1:0] hrdata;
    logic              hreadyout;
    logic [1:0]        hresp;

    modport slave (
        input  hwrite, hreadyin, htrans, haddr, hwdata, prdata, hready_apb,
        output valid, tempselx, haddr1, haddr2, hwdata1, hwdata2,
               hwrite_reg, hwrite_reg1, hrdata, hreadyout, hresp
    );

    modport master (
        output hwrite, hreadyin, htrans, haddr, hwdata, prdata, hready_apb,
        input  valid, tempselx, haddr1, haddr2, hwdata1, hwdata2,
               hwrite_reg, hwrite_reg1, hrdata, hreadyout, hresp
    );
endinterface

// File: rtl/ahb_slave_if.sv
// -----------------------------------------------------------------------------
// ahb_slave_if
// AHB-side slave interface of the AHB-APB bridge. Qualifies AHB transfers,
// decodes haddr[31:26] into a one-hot select over three 64 MB regions,
// pipelines address / write data / direction over two stages for the APB
// controller, passes prdata straight back as hrdata and generates the
// hready/hresp response.
//
// Ports
//   hclk    : bridge clock, all state on posedge
//   hresetn : asynchronous active-low reset
//   bus     : ahb_slave_if_if.slave bundle (see interface file)
//
// Configuration macro: AHB_SLV_ERR_RESP_EN
//   defined   : out-of-map NONSEQ/SEQ transfers get a two-cycle ERROR
//               response (ERR1: hreadyout=0, ERR2: hreadyout=1, hresp=01).
//   undefined : no error FSM, hresp=00, hreadyout=hready_apb; out-of-map
//               transfers are simply not flagged valid.
// -----------------------------------------------------------------------------
module ahb_slave_if #(
    parameter int          ADDR_W    = 32,
    parameter int          DATA_W    = 32,
    parameter logic [31:0] SEL0_BASE = 32'h8000_0000,
    parameter logic [31:0] SEL1_BASE = 32'h8400_0000,
    parameter logic [31:0] SEL2_BASE = 32'h8800_0000
) (
    input  logic           hclk,
    input  logic           hresetn,
    ahb_slave_if_if.slave  bus
);

    // Only the top six address bits identify a 64 MB region.
    localparam logic [2:0][5:0] BASE_TAGS = {SEL2_BASE[31:26],
                                             SEL1_BASE[31:26],
                                             SEL0_BASE[31:26]};

    wire [2:0] sel_hit;
    logic      xfer_req;
    logic      in_map;

    // Decode on the live address-phase haddr, not the pipelined copy.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_dec
            assign sel_hit[gi] = (bus.haddr[ADDR_W-1 -: 6] == BASE_TAGS[gi]);
        end
    endgenerate

    // htrans[1] is set for NONSEQ and SEQ only; IDLE and BUSY never qualify.
    assign xfer_req     = bus.hreadyin & bus.htrans[1];
    assign in_map       = |sel_hit;
    assign bus.tempselx = sel_hit;
    assign bus.hrdata   = bus.prdata;

`ifdef AHB_SLV_ERR_RESP_EN
    typedef enum logic [1:0] {
        ST_OKAY = 2'd0,
        ST_ERR1 = 2'd1,
        ST_ERR2 = 2'd2
    } state_e;

    state_e     state_q;
    logic [1:0] hresp_q;
    logic       err_rdy_q;   // hreadyout value while in an error state
    logic       in_okay;

    assign in_okay = (state_q == ST_OKAY);

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q   <= ST_OKAY;
            hresp_q   <= 2'b00;
            err_rdy_q <= 1'b0;
        end else begin
            case (state_q)
                ST_OKAY: begin
                    if (xfer_req && !in_map) begin
                        state_q   <= ST_ERR1;
                        hresp_q   <= 2'b01;
                        err_rdy_q <= 1'b0;
                    end
                end
                // Two-cycle error: first cycle stalls the master, second
                // completes it so the master can cancel the next transfer.
                ST_ERR1: begin
                    state_q   <= ST_ERR2;
                    hresp_q   <= 2'b01;
                    err_rdy_q <= 1'b1;
                end
                ST_ERR2: begin
                    state_q   <= ST_OKAY;
                    hresp_q   <= 2'b00;
                    err_rdy_q <= 1'b0;
                end
                default: begin
                    state_q   <= ST_OKAY;
                    hresp_q   <= 2'b00;
                    err_rdy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.valid     = xfer_req & in_map & in_okay;
    assign bus.hresp     = hresp_q;
    assign bus.hreadyout = in_okay ? bus.hready_apb : err_rdy_q;
`else
    assign bus.valid     = xfer_req & in_map;
    assign bus.hresp     = 2'b00;
    assign bus.hreadyout = bus.hready_apb;
`endif

    // Two-stage pipeline; advances only when the master is ready. Write data
    // is captured on the same edges as the address, so hwdata1 naturally
    // holds the data phase belonging to the previous address.
    logic [ADDR_W-1:0] haddr1_q, haddr2_q;
    logic [DATA_W-1:0] hwdata1_q, hwdata2_q;
    logic              hwrite1_q, hwrite2_q;

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            haddr1_q  <= '0;
            haddr2_q  <= '0;
            hwdata1_q <= '0;
            hwdata2_q <= '0;
            hwrite1_q <= 1'b0;
            hwrite2_q <= 1'b0;
        end else if (bus.hreadyin) begin
            haddr1_q  <= bus.haddr;
            haddr2_q  <= haddr1_q;
            hwdata1_q <= bus.hwdata;
            hwdata2_q <= hwdata1_q;
            hwrite1_q <= bus.hwrite;
            hwrite2_q <= hwrite1_q;
        end
    end

    assign bus.haddr1      = haddr1_q;
    assign bus.haddr2      = haddr2_q;
    assign bus.hwdata1     = hwdata1_q;
    assign bus.hwdata2     = hwdata2_q;
    assign bus.hwrite_reg  = hwrite1_q;
    assign bus.hwrite_reg1 = hwrite2_q;

endmodule

// File: tb/tb_ahb_slave_if.sv
// -----------------------------------------------------------------------------
// tb_ahb_slave_if
// Scoreboard bench for ahb_slave_if. A driver applies one bus cycle per clock
// (just after posedge), steps a behavioural reference model and queues the
// expected outputs; a monitor samples the DUT at negedge and compares.
// Honours AHB_SLV_ERR_RESP_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_ahb_slave_if;

    logic clk;
    logic rst_n;

    ahb_slave_if_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    ahb_slave_if dut (
        .hclk    (clk),
        .hresetn (rst_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        valid;
        logic [2:0]  sel;
        logic [1:0]  hresp;
        logic        hreadyout;
        logic [31:0] hrdata;
        logic [31:0] haddr1;
        logic [31:0] haddr2;
        logic [31:0] hwdata1;
        logic [31:0] hwdata2;
        logic        hwrite_reg;
        logic        hwrite_reg1;
        string       tag;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic        w;
    } beat_t;

    exp_t  sb[$];
    beat_t hist[$];          // hist[0] = most recently accepted beat
    int    err_left;         // remaining error-response cycles (0 = OKAY)
    int    tests, fails;
    bit    err_en;

    // previous-cycle inputs, applied to the model at the next posedge
    logic        p_rn, p_rdy, p_w;
    logic [1:0]  p_tr;
    logic [31:0] p_a, p_d;

    // Region index from plain address arithmetic: 64 MB slots from 8000_0000.
    function automatic int region(input logic [31:0] a);
        if (a >= 32'h8000_0000 && a < 32'h8C00_0000)
            return int'((a - 32'h8000_0000) >> 26);
        return -1;
    endfunction

    task automatic model_reset();
        beat_t z;
        z.a = '0; z.d = '0; z.w = 1'b0;
        hist = '{z, z};
        err_left = 0;
    endtask

    task automatic model_edge();
        beat_t b;
        if (err_left > 0)
            err_left = err_left - 1;
        else if (err_en && p_rdy && p_tr >= 2 && region(p_a) < 0)
            err_left = 2;
        if (p_rdy) begin
            b.a = p_a; b.d = p_d; b.w = p_w;
            hist.push_front(b);
            void'(hist.pop_back());
        end
    endtask

    task automatic cyc(input logic rn, input logic rdy, input logic [1:0] tr,
                       input logic [31:0] a, input logic w, input logic [31:0] d,
                       input string tag);
        exp_t e;
        int   r;
        logic [31:0] pr;
        logic        ra;
        pr = $urandom;
        ra = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        if (p_rn) model_edge();
        rst_n          = rn;
        bus.hreadyin   = rdy;
        bus.htrans     = tr;
        bus.haddr      = a;
        bus.hwrite     = w;
        bus.hwdata     = d;
        bus.prdata     = pr;
        bus.hready_apb = ra;
        if (!rn) model_reset();
        p_rn = rn; p_rdy = rdy; p_tr = tr; p_a = a; p_w = w; p_d = d;

        r = region(a);
        e.sel         = (r >= 0) ? 3'(1 << r) : 3'b000;
        e.valid       = rdy && tr >= 2 && r >= 0 && err_left == 0;
        e.hresp       = (err_left != 0) ? 2'b01 : 2'b00;
        e.hreadyout   = (err_left == 2) ? 1'b0 : (err_left == 1) ? 1'b1 : ra;
        e.hrdata      = pr;
        e.haddr1      = hist[0].a;
        e.haddr2      = hist[1].a;
        e.hwdata1     = hist[0].d;
        e.hwdata2     = hist[1].d;
        e.hwrite_reg  = hist[0].w;
        e.hwrite_reg1 = hist[1].w;
        e.tag         = tag;
        sb.push_back(e);
    endtask

    task automatic chk(input string tag, input string n,
                       input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s.%s actual=%h required=%h", tag, n, act, exp);
        end
    endtask

    // Monitor: compares one queued expectation per clock, mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk(e.tag, "valid",       32'(bus.valid),       32'(e.valid));
                chk(e.tag, "tempselx",    32'(bus.tempselx),    32'(e.sel));
                chk(e.tag, "hresp",       32'(bus.hresp),       32'(e.hresp));
                chk(e.tag, "hreadyout",   32'(bus.hreadyout),   32'(e.hreadyout));
                chk(e.tag, "hrdata",      bus.hrdata,           e.hrdata);
                chk(e.tag, "haddr1",      bus.haddr1,           e.haddr1);
                chk(e.tag, "haddr2",      bus.haddr2,           e.haddr2);
                chk(e.tag, "hwdata1",     bus.hwdata1,          e.hwdata1);
                chk(e.tag, "hwdata2",     bus.hwdata2,          e.hwdata2);
                chk(e.tag, "hwrite_reg",  32'(bus.hwrite_reg),  32'(e.hwrite_reg));
                chk(e.tag, "hwrite_reg1", 32'(bus.hwrite_reg1), 32'(e.hwrite_reg1));
                $display("[MON] %-12s valid=%0b sel=%03b hresp=%0d hrdy=%0b a1=%h a2=%h d1=%h d2=%h",
                         e.tag, bus.valid, bus.tempselx, bus.hresp, bus.hreadyout,
                         bus.haddr1, bus.haddr2, bus.hwdata1, bus.hwdata2);
            end
        end
    end

    localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, NSEQ = 2'd2, SEQ = 2'd3;

    initial begin
        logic [31:0] bad_list [4];
        logic [31:0] a;
        logic [1:0]  tr;
        int          k;
`ifdef AHB_SLV_ERR_RESP_EN
        err_en = 1'b1;
`else
        err_en = 1'b0;
`endif
        tests = 0; fails = 0;
        bad_list = '{32'h9000_0000, 32'h0000_1000, 32'h8C00_0000, 32'h7FFF_FFFC};
        rst_n = 1'b0;
        bus.hreadyin = 1'b1; bus.htrans = IDLE; bus.haddr = '0; bus.hwrite = 1'b0;
        bus.hwdata = '0; bus.prdata = '0; bus.hready_apb = 1'b1;
        p_rn = 1'b0; p_rdy = 1'b0; p_tr = IDLE; p_a = '0; p_w = 1'b0; p_d = '0;
        model_reset();

        cyc(0, 1, IDLE, 32'h0, 0, 32'h0, "reset");
        cyc(0, 1, NSEQ, 32'h9000_0000, 0, 32'h0, "reset2");

        // single write
        cyc(1, 1, NSEQ, 32'h8000_0000, 1, 32'h0,  "wr_addr");
        cyc(1, 1, IDLE, 32'h0,         0, 32'd24, "wr_data");
        cyc(1, 1, IDLE, 32'h0,         0, 32'h0,  "wr_idle");

        // INCR4 read
        cyc(1, 1, NSEQ, 32'h8400_0000, 0, 32'h0, "incr4_0");
        cyc(1, 1, SEQ,  32'h8400_0001, 0, 32'h0, "incr4_1");
        cyc(1, 1, SEQ,  32'h8400_0002, 0, 32'h0, "incr4_2");
        cyc(1, 1, SEQ,  32'h8400_0003, 0, 32'h0, "incr4_3");
        cyc(1, 1, IDLE, 32'h0,         0, 32'h0, "incr4_end");

        // write burst with a two-cycle master stall
        cyc(1, 1, NSEQ, 32'h8800_0000, 1, 32'h0,  "stall_0");
        cyc(1, 1, SEQ,  32'h8800_0004, 1, 32'd11, "stall_1");
        cyc(1, 0, SEQ,  32'h8800_0008, 1, 32'd22, "stall_w0");
        cyc(1, 0, SEQ,  32'h8800_0008, 1, 32'd22, "stall_w1");
        cyc(1, 1, SEQ,  32'h8800_0008, 1, 32'd22, "stall_2");
        cyc(1, 1, SEQ,  32'h8800_000C, 1, 32'd33, "stall_3");
        cyc(1, 1, IDLE, 32'h0,         0, 32'd44, "stall_end");

        // out-of-map: error sequence, ignored transfers, fresh error after ERR2
        cyc(1, 1, NSEQ, 32'h9000_0000, 0, 32'h0, "err_addr");
        cyc(1, 1, NSEQ, 32'h9000_0004, 0, 32'h0, "err1_bad");
        cyc(1, 1, NSEQ, 32'h8000_0040, 0, 32'h0, "err2_good");
        cyc(1, 1, NSEQ, 32'h9100_0000, 0, 32'h0, "err_again");
        cyc(1, 1, IDLE, 32'h0,         0, 32'h0, "err_idle0");
        cyc(1, 1, IDLE, 32'h0,         0, 32'h0, "err_idle1");
        cyc(1, 1, IDLE, 32'h0,         0, 32'h0, "err_idle2");

        // SEQ leaving region 2
        cyc(1, 1, NSEQ, 32'h8BFF_FFFC, 0, 32'h0, "cross_0");
        cyc(1, 1, SEQ,  32'h8C00_0000, 0, 32'h0, "cross_1");
        cyc(1, 1, IDLE, 32'h0,         0, 32'h0, "cross_i0");
        cyc(1, 1, IDLE, 32'h0,         0, 32'h0, "cross_i1");

        // BUSY inside a burst
        cyc(1, 1, NSEQ, 32'h8000_0010, 1, 32'h0,  "busy_0");
        cyc(1, 1, BUSY, 32'h8000_0014, 1, 32'd5,  "busy_1");
        cyc(1, 1, SEQ,  32'h8000_0014, 1, 32'd5,  "busy_2");
        cyc(1, 1, IDLE, 32'h0,         0, 32'd6,  "busy_end");

        // reset asserted while in ERR1 (mid-cycle, checked before next edge)
        cyc(1, 1, NSEQ, 32'h9000_0000, 1, 32'h0, "rst_bad");
        cyc(0, 1, IDLE, 32'h0,         0, 32'h0, "rst_in_err1");
        cyc(1, 1, IDLE, 32'h0,         0, 32'h0, "rst_rel");

        // randomized traffic
        for (int i = 0; i < 200; i++) begin
            k = $urandom_range(0, 9);
            if (k < 7)
                a = 32'h8000_0000 + (32'($urandom_range(0, 2)) << 26)
                    + ($urandom & 32'h03FF_FFFC);
            else
                a = bad_list[$urandom_range(0, 3)];
            tr = 2'($urandom_range(0, 3));
            cyc(1, ($urandom_range(0, 4) != 0), tr, a, 1'($urandom_range(0, 1)),
                $urandom, "rand");
        end

        // drain scoreboard with a bound
        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain actual=%0d entries required=0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
